// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   size_e  - request access size encoding (2'b11 is illegal and has no name)
//   state_e - LSU control FSM states
package lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the LSU.
//   word        - 32-bit memory word (captured read data)
//   addr_lo     - byte offset within the word
//   size        - access size (byte / halfword / word)
//   is_unsigned - 1 = zero-extend loads, 0 = sign-extend
//   wdata       - right-aligned store data
//   load_data   - selected lane, extended to 32 bits
//   merge_data  - word to write back (store lane merged into word; wdata for word stores)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (addr_lo)
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      2'd3:    byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      SZ_B:    load_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_H:    load_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default: load_data = word;
    endcase

    merge_data = word;
    case (size)
      SZ_B: begin
        case (addr_lo)
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data[7:0]   = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
        else            merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit in front of a word-wide memory.
//   clk, reset             - clock and asynchronous active-high reset
//   req_valid/req_ready    - request handshake (ready only in IDLE)
//   req_we/size/unsigned   - store/load, access size, load extension
//   req_addr/req_wdata     - byte address and right-aligned store data
//   resp_valid/rdata/err   - one-cycle completion pulse with load data / error flag
//   mem_we/mem_a/mem_wd    - memory write enable, word address, write word
//   mem_rd                 - combinational read word at mem_a
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                               req_err = 1'b1;
    if (req_size == SZ_H && req_addr[0])                 req_err = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00)      req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))       req_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = req_err;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_err)                        state_d = RESP;
          else if (req_we && req_size == SZ_W) state_d = WRITE;
          else                                state_d = READ;
        end
      end
      READ: begin
        rword_d = mem_rd;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
    end
  end

  lsu_align u_align (
    .word        (rword_q),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // Outputs decode from the registered state only, so reset clears them at once.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_data : '0;
  assign mem_we     = (state_q == WRITE);
  assign mem_a      = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wd     = (state_q == WRITE) ? merge_data : '0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu with a memory model, directed cases and random traffic.
module tb_lsu;

  localparam int unsigned MW = 256;
  localparam int unsigned AW = $clog2(MW);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  lsu #(.MEM_WORDS(MW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  always #5 clk = ~clk;

  // Attached memory, with a backdoor port for preloading.
  logic [31:0]   mem [MW];
  logic          bd_we;
  logic [AW-1:0] bd_idx;
  logic [31:0]   bd_data;
  assign mem_rd = mem[mem_a[AW+1:2]];
  always @(posedge clk) begin
    if (bd_we)       mem[bd_idx] <= bd_data;
    else if (mem_we) mem[mem_a[AW+1:2]] <= mem_wd;
  end

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [MW];

  function automatic bit model_err(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    if (a[31:2] >= MW) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] sz, bit u, logic [1:0] off);
    int unsigned bits, v;
    bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    if (bits == 32) return w;
    v = (w >> (8 * off)) & ((32'd1 << bits) - 1);
    if (!u && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] wd, logic [1:0] sz, logic [1:0] off);
    logic [31:0] mask;
    if (sz == 2'b10) return wd;
    mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  bit          pend = 1'b0;
  int          rc, wc, rdc, acc;
  logic        exp_err;
  logic [31:0] exp_rd, exp_wd, exp_a, sold;
  int unsigned sidx;
  bit          is_st, rdy, rsp, merr;

  // Single compare process: checks every cycle, then books any request accepted at the next edge.
  always @(negedge clk) begin
    if (bd_we) ref_mem[bd_idx] = bd_data;
    if (reset) begin
      chk("reset_ready", req_ready, 1);
      chk("reset_resp_valid", resp_valid, 0);
      chk("reset_resp_err", resp_err, 0);
      chk("reset_resp_rdata", resp_rdata, 0);
      chk("reset_mem_we", mem_we, 0);
      chk("reset_mem_a", mem_a, 0);
      chk("reset_mem_wd", mem_wd, 0);
      if (pend && is_st && cyc <= wc) ref_mem[sidx] = sold;
      pend = 1'b0;
    end else begin
      rdy = !pend;
      rsp = pend && cyc == rc;
      chk("req_ready", req_ready, rdy);
      chk("resp_valid", resp_valid, rsp);
      if (rsp) begin
        chk("resp_err", resp_err, exp_err);
        chk("resp_rdata", resp_rdata, exp_rd);
      end
      chk("mem_we", mem_we, pend && cyc == wc);
      if (pend && cyc == wc) begin
        chk("write_mem_a", mem_a, exp_a);
        chk("write_mem_wd", mem_wd, exp_wd);
      end
      if (pend && cyc == rdc) chk("read_mem_a", mem_a, exp_a);
      if (!pend || rsp) begin
        chk("idle_mem_a", mem_a, 0);
        chk("idle_mem_wd", mem_wd, 0);
      end
      if (rsp) pend = 1'b0;
      if (rdy && req_valid) begin
        acc     = cyc + 1;
        merr    = model_err(req_size, req_addr);
        sidx    = req_addr[AW+1:2];
        exp_a   = {req_addr[31:2], 2'b00};
        exp_err = merr;
        exp_rd  = '0;
        is_st   = req_we && !merr;
        rdc = -1; wc = -1;
        if (merr) begin
          rc = acc;
        end else if (!req_we) begin
          rdc = acc; rc = acc + 1;
          exp_rd = model_load(ref_mem[sidx], req_size, req_unsigned, req_addr[1:0]);
        end else begin
          if (req_size == 2'b10) begin wc = acc; rc = acc + 1; end
          else begin rdc = acc; wc = acc + 1; rc = acc + 2; end
          sold   = ref_mem[sidx];
          exp_wd = model_store(sold, req_wdata, req_size, req_addr[1:0]);
          ref_mem[sidx] = exp_wd;
        end
        pend = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic poke(input int unsigned idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx[AW-1:0]; bd_data = d;
    @(negedge clk);
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic drive(input bit we, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    #2;
    chk("por_ready", req_ready, 1);
    chk("por_resp_valid", resp_valid, 0);
    chk("por_mem_we", mem_we, 0);
    for (int i = 0; i < int'(MW); i++) poke(i, $urandom);
    poke(1, 32'h80FF7F01);
    poke(2, 32'h11223344);
    poke(3, 32'hCAFEF00D);
    reset = 1'b0;
    @(posedge clk); #1;

    // signed byte load, lane 2
    drive(0, 2'b00, 0, 32'h6, 0);
    repeat (2) @(negedge clk);
    chk("lb_valid", resp_valid, 1);
    chk("lb_rdata", resp_rdata, 32'hFFFFFFFF);
    chk("lb_err", resp_err, 0);
    @(posedge clk); #1;

    // unsigned halfword load, upper half
    drive(0, 2'b01, 1, 32'h6, 0);
    repeat (2) @(negedge clk);
    chk("lhu_rdata", resp_rdata, 32'h000080FF);
    @(posedge clk); #1;

    // byte store into lane 1
    drive(1, 2'b00, 0, 32'h9, 32'h000000AA);
    @(negedge clk);
    chk("sb_read_we", mem_we, 0);
    @(negedge clk);
    chk("sb_we", mem_we, 1);
    chk("sb_wd", mem_wd, 32'h1122AA44);
    @(negedge clk);
    chk("sb_valid", resp_valid, 1);
    chk("sb_mem", mem[2], 32'h1122AA44);
    @(posedge clk); #1;

    // misaligned word load and out-of-range word load
    drive(0, 2'b10, 0, 32'h2, 0);
    @(negedge clk);
    chk("mis_valid", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    chk("mis_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    drive(0, 2'b10, 0, 32'h400, 0);
    @(negedge clk);
    chk("oor_err", resp_err, 1);
    chk("oor_we", mem_we, 0);
    @(posedge clk); #1;

    // back-to-back word store then load with req_valid held
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_we = 1'b0;
    @(negedge clk); chk("b2b_busy0", req_ready, 0);
    @(negedge clk); chk("b2b_busy1", req_ready, 0);
    @(negedge clk); chk("b2b_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); chk("b2b_busy2", req_ready, 0);
    @(negedge clk);
    chk("b2b_valid", resp_valid, 1);
    chk("b2b_rdata", resp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // reset during WRITE of a halfword store
    drive(1, 2'b01, 0, 32'hC, 32'h00001234);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 0);
    end
    chk("abort_mem", mem[3], 32'hCAFEF00D);
    @(posedge clk); #1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      req_we       = $urandom_range(0, 1);
      req_size     = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      req_unsigned = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) req_addr = $urandom;
      else req_addr = {$urandom_range(0, MW - 1), 2'($urandom_range(0, 3))};
      req_wdata    = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < int'(MW); i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit words in the attached memory; word addresses at or above this SHALL be out of range.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request; it is 1 only in IDLE.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend a load, 0 = sign-extend a load.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-013 The block SHALL have port resp_err, output, 1 bit: the request was misaligned, out of range or illegal-size; valid only with resp_valid.
REQ-014 The block SHALL have port mem_we, output, 1 bit: word write enable to the memory; the memory commits the write on the clk rising edge.
REQ-015 The block SHALL have port mem_a, output, 32 bits: byte address of the word; the memory ignores bits [1:0].
REQ-016 The block SHALL have port mem_wd, output, 32 bits: full word to write.
REQ-017 The block SHALL have port mem_rd, input, 32 bits: the word at mem_a, combinational, same cycle.

Function
REQ-018 The block SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-019 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; all request fields SHALL be registered at acceptance.
REQ-020 An accepted request SHALL transition as follows:
- error request: IDLE->RESP;
- load or sub-word store: IDLE->READ;
- word store: IDLE->WRITE.
REQ-021 READ SHALL drive mem_a = {addr[31:2],2'b00} and mem_we=0, and SHALL capture mem_rd at the end of the cycle; it then goes to RESP for a load or to WRITE for a store.
REQ-022 WRITE SHALL drive mem_we=1 for exactly one cycle, with mem_wd as follows:
- word store: req_wdata;
- sub-word store: the captured word with only the addressed byte or halfword lane replaced by the low bits of req_wdata.
After WRITE the FSM goes to RESP.
REQ-023 RESP SHALL assert resp_valid for exactly one cycle and then return to IDLE; there is no response backpressure.
REQ-024 Latency from the acceptance edge to resp_valid SHALL be: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-025 A request SHALL be an error when any of the following holds:
- size 11;
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- addr[31:2] >= MEM_WORDS.
An error SHALL produce no memory access and mem_we SHALL stay 0.
REQ-026 Load extraction SHALL select byte lane addr[1:0] or halfword lane addr[1], then sign- or zero-extend it to 32 bits per req_unsigned.
REQ-027 Outside WRITE, mem_we SHALL be 0; outside READ/WRITE, mem_a and mem_wd SHALL be 0.
REQ-028 A req_valid held while the block is not in IDLE SHALL be ignored until the block returns to IDLE.

Reset
REQ-029 Reset SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_a=0 and mem_wd=0.
REQ-030 Reset asserted during READ or WRITE SHALL abort the operation with no write committed, and no response SHALL follow it.

Structure
REQ-031 Package lsu_pkg SHALL hold:
- the size enum (SZ_B, SZ_H, SZ_W);
- the FSM state enum;
- the constant WORD_BYTES=4.
REQ-032 Lane extraction/extension and store-lane merging SHALL be placed in one combinational sub-module, lsu_align.

Verification
REQ-033 Load byte, signed: mem[1]=32'h80FF7F01, request addr 32'h6, size 00, unsigned 0 -> resp_rdata=32'hFFFFFFFF (lane 2 = 0xFF) two cycles after acceptance, resp_err=0.
REQ-034 Load halfword, unsigned: mem[1]=32'h80FF7F01, addr 32'h6, size 01, unsigned 1 -> resp_rdata=32'h000080FF.
REQ-035 Sub-word store: mem[2]=32'h11223344, store byte 8'hAA at addr 32'h9 -> exactly one mem_we pulse, in the second cycle after acceptance, with mem_wd=32'h1122AA44; resp_valid in the third cycle.
REQ-036 Errors: word load at addr 32'h2, and a word load at addr 32'h400 with MEM_WORDS=256 -> each gives resp_err=1 one cycle after acceptance, mem_we never asserted, resp_rdata=0.
REQ-037 Back-to-back: req_valid held high for a word store followed by a word load at the same address -> req_ready is low for 2 cycles after each acceptance, and the load returns the stored data.
REQ-038 Reset asserted during WRITE of a sub-word store -> state IDLE immediately, no resp_valid, and the target word is unchanged.
